// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Optional perf counters are enabled with FETCH_PERF_EN.
package fetch_pkg;

  localparam int INSTR_W = 24;
  localparam int ADDR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = '0;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic branch;
    logic kill;
    logic hold;
    logic adv;
  } ctrl_t;

  // Resolve branchTaken > flush > stall > advance into one-hot.
  function automatic ctrl_t decode_ctrl(
    input logic branch,
    input logic flush,
    input logic stall
  );
    ctrl_t c;
    c.branch = branch;
    c.kill = flush & ~branch;
    c.hold = stall & ~flush & ~branch;
    c.adv = ~stall & ~flush & ~branch;
    return c;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage control, ROM and decode-side signal bundle.
// FETCH_PERF_EN adds the fetchCount / stallCount outputs.
interface fetch_stage_if #(
  parameter int WIDTH = 32,
  parameter int INSTRUCTIONWIDTH = 24
);

  logic stall;
  logic flush;
  logic branchTaken;
  logic [WIDTH-1:0] branchTarget;
  logic [WIDTH-1:0] imemAddr;
  logic [INSTRUCTIONWIDTH-1:0] imemData;
  logic [WIDTH-1:0] PC;
  logic [INSTRUCTIONWIDTH-1:0] instruction;
  logic validD;
`ifdef FETCH_PERF_EN
  logic [WIDTH-1:0] fetchCount;
  logic [WIDTH-1:0] stallCount;

  modport master (
    input stall, flush, branchTaken,
    input branchTarget, imemData,
    output imemAddr, PC, instruction,
    output validD, fetchCount, stallCount
  );

  modport slave (
    output stall, flush, branchTaken,
    output branchTarget, imemData,
    input imemAddr, PC, instruction,
    input validD, fetchCount, stallCount
  );
`else
  modport master (
    input stall, flush, branchTaken,
    input branchTarget, imemData,
    output imemAddr, PC, instruction,
    output validD
  );

  modport slave (
    output stall, flush, branchTaken,
    output branchTarget, imemData,
    input imemAddr, PC, instruction,
    input validD
  );
`endif

endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch program counter with branch / hold / increment select.
// Wraps modulo 2^WIDTH.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESETPC = WIDTH'(RESET_PC)
) (
  input  logic clk,
  input  logic reset,
  input  logic branch,
  input  logic hold,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESETPC;
    end else begin
      unique case (1'b1)
        branch: pc <= target;
        hold: pc <= pc;
        default: pc <= pc + WIDTH'(1);
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, ROM alignment, stall/flush/branch.
// Define FETCH_PERF_EN for fetchCount / stallCount counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0] RESETPC = WIDTH'(RESET_PC)
) (
  input logic clk,
  input logic reset,
  fetch_stage_if.master bus
);

  localparam logic [INSTRUCTIONWIDTH-1:0] BUBBLE =
    INSTRUCTIONWIDTH'(NOP);

  ctrl_t ctrl;
  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] pc_d;
  logic valid_d;
  logic [INSTRUCTIONWIDTH-1:0] hold_instr;
  state_t state;

  assign ctrl = decode_ctrl(
    bus.branchTaken, bus.flush, bus.stall);

  fetch_pc_gen #(
    .WIDTH(WIDTH),
    .RESETPC(RESETPC)
  ) u_pc_gen (
    .clk(clk),
    .reset(reset),
    .branch(ctrl.branch),
    .hold(ctrl.hold),
    .target(bus.branchTarget),
    .pc(pc_f)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_d <= '0;
      valid_d <= 1'b0;
      hold_instr <= BUBBLE;
      state <= RUN;
    end else begin
      unique case (1'b1)
        ctrl.branch: begin
          valid_d <= 1'b0;
          state <= RUN;
        end
        ctrl.kill: begin
          pc_d <= pc_f;
          valid_d <= 1'b0;
          state <= RUN;
        end
        ctrl.hold: begin
          // Capture once; the ROM re-reads pc_f meanwhile.
          if (state == RUN) begin
            hold_instr <= bus.imemData;
            state <= HOLD;
          end
        end
        default: begin
          pc_d <= pc_f;
          valid_d <= 1'b1;
          state <= RUN;
        end
      endcase
    end
  end

  always_comb begin
    bus.instruction = BUBBLE;
    if (valid_d) begin
      if (state == HOLD) begin
        bus.instruction = hold_instr;
      end else begin
        bus.instruction = bus.imemData;
      end
    end
  end

  assign bus.imemAddr = pc_f;
  assign bus.PC = pc_d;
  assign bus.validD = valid_d;

`ifdef FETCH_PERF_EN
  logic [WIDTH-1:0] fetch_count;
  logic [WIDTH-1:0] stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (ctrl.adv) begin
        fetch_count <= fetch_count + WIDTH'(1);
      end
      if (bus.stall && !bus.branchTaken) begin
        stall_count <= stall_count + WIDTH'(1);
      end
    end
  end

  assign bus.fetchCount = fetch_count;
  assign bus.stallCount = stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a stream-level reference model.
// Also checks perf counters when FETCH_PERF_EN is defined.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int W = 32;
  localparam int IW = 24;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.WIDTH(W), .INSTRUCTIONWIDTH(IW)) bus ();

  fetch_stage #(
    .WIDTH(W),
    .INSTRUCTIONWIDTH(IW),
    .RESETPC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [IW-1:0] rom(input logic [W-1:0] a);
    return IW'(a + 32'd1);
  endfunction

  logic [IW-1:0] rom_q;
  always @(posedge clk) rom_q <= rom(bus.imemAddr);
  assign bus.imemData = rom_q;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] addr;
    logic valid;
    logic [IW-1:0] ins;
    logic [W-1:0] fc;
    logic [W-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  // Reference model: fetch stream position and what decode sees.
  logic [W-1:0] m_next;
  logic [W-1:0] m_pc;
  logic m_valid;
  logic [W-1:0] m_fc;
  logic [W-1:0] m_sc;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_next = 32'h0;
    m_pc = 32'h0;
    m_valid = 1'b0;
    m_fc = 32'h0;
    m_sc = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, 64'(bus.PC), 64'h0);
    check({tag, "_ins"}, 64'(bus.instruction), 64'h0);
    check({tag, "_valid"}, 64'(bus.validD), 64'h0);
    check({tag, "_addr"}, 64'(bus.imemAddr), 64'h0);
`ifdef FETCH_PERF_EN
    check({tag, "_fcnt"}, 64'(bus.fetchCount), 64'h0);
    check({tag, "_scnt"}, 64'(bus.stallCount), 64'h0);
`endif
  endtask

  // Drive one cycle of control, predict the post-edge view.
  task automatic issue(input bit b, input bit f, input bit s,
                       input logic [W-1:0] t);
    exp_t e;
    bus.branchTaken = b;
    bus.flush = f;
    bus.stall = s;
    bus.branchTarget = t;
    if (s && !b) m_sc = m_sc + 32'd1;
    if (b) begin
      m_valid = 1'b0;
      m_next = t;
    end else if (f) begin
      m_valid = 1'b0;
      m_next = m_next + 32'd1;
    end else if (!s) begin
      m_pc = m_next;
      m_valid = 1'b1;
      m_next = m_next + 32'd1;
      m_fc = m_fc + 32'd1;
    end
    e.pc = m_pc;
    e.addr = m_next;
    e.valid = m_valid;
    e.ins = m_valid ? rom(m_pc) : NOP;
    e.fc = m_fc;
    e.sc = m_sc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        check("valid", 64'(bus.validD), 64'(e.valid));
        check("ins", 64'(bus.instruction), 64'(e.ins));
        check("addr", 64'(bus.imemAddr), 64'(e.addr));
        if (e.valid) check("pc", 64'(bus.PC), 64'(e.pc));
`ifdef FETCH_PERF_EN
        check("fcnt", 64'(bus.fetchCount), 64'(e.fc));
        check("scnt", 64'(bus.stallCount), 64'(e.sc));
`endif
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      bit b, f, s;
      logic [W-1:0] t;
      r = int'($urandom_range(0, 99));
      b = (r < 10);
      f = (r >= 10 && r < 18) || ($urandom_range(0, 15) == 0);
      s = (r >= 18 && r < 42) || ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        t = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else
        t = 32'($urandom());
      issue(b, f, s, t);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.branchTaken = 1'b0;
    bus.branchTarget = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    #1;
    check_reset_outputs("pre1");

    repeat (3) issue(0, 0, 0, 0);
    repeat (3) issue(0, 0, 1, 0);
    repeat (2) issue(0, 0, 0, 0);
    issue(1, 0, 0, 32'h10);
    repeat (2) issue(0, 0, 0, 0);
    issue(1, 0, 1, 32'h10);
    repeat (2) issue(0, 0, 0, 0);
    issue(1, 0, 0, 32'h5);
    issue(0, 0, 0, 0);
    issue(0, 1, 0, 0);
    repeat (2) issue(0, 0, 0, 0);
    issue(1, 0, 0, 32'hFFFF_FFFE);
    repeat (3) issue(0, 0, 0, 0);
    issue(0, 1, 1, 0);
    issue(1, 0, 0, 32'h40);
    repeat (2) issue(0, 0, 1, 0);
    repeat (2) issue(0, 0, 0, 0);

    random_run(400);

    repeat (2) issue(0, 0, 0, 0);
    repeat (2) issue(0, 0, 1, 0);
    drain();
    #2;
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.branchTaken = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    repeat (2) issue(0, 0, 0, 0);
    random_run(300);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end that produces the PC / instruction pair consumed by the decode stage.
- Owns the program counter and issues word addresses to a synchronous instruction ROM with one-cycle read latency.
- Aligns returned data with its PC and handles decode-stage stalls (hold), branch redirects and pipeline flushes, inserting NOP bubbles when no valid instruction is available.

Parameters:
- WIDTH, 32, PC / address width.
- INSTRUCTIONWIDTH, 24, instruction word width.
- RESETPC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  decode cannot accept; hold the current output.
- flush  input  1  kill the instruction currently presented to decode.
- branchTaken  input  1  redirect fetch this cycle.
- branchTarget  input  WIDTH  redirect address.
- imemAddr  output  WIDTH  ROM address; equals pcF.
- imemData  input  INSTRUCTIONWIDTH  ROM data for the address presented on the previous edge.
- PC  output  WIDTH  PC of the presented instruction (pcD).
- instruction  output  INSTRUCTIONWIDTH  instruction to decode.
- validD  output  1  presented instruction is real (not a bubble).

Behaviour:
- Registers:
  - pcF: next address to issue.
  - pcD, validD: the second stage.
  - holdInstr.
  - state: RUN or HOLD.
- Reset (async, reset=0): pcF=RESETPC, pcD=0, validD=0, holdInstr=NOP, state=RUN. Outputs: imemAddr=RESETPC, PC=0, instruction=NOP, validD=0.
- Latency: the first valid instruction appears 1 cycle after reset release (PC=RESETPC). Thereafter 1 instruction per cycle, with no bubbles while stall=flush=branchTaken=0.
- The address increments by 1 per instruction (word-addressed). pcF+1 wraps modulo 2^WIDTH.
- instruction output:
  - validD=0: NOP.
  - state=HOLD: holdInstr.
  - otherwise: imemData.
- Per edge, priority order branchTaken > flush > stall > normal:
  - branchTaken=1: pcF<=branchTarget; validD<=0; state<=RUN. The in-flight instruction is killed regardless of stall.
  - flush=1 (no branch): pcD<=pcF; pcF<=pcF+1; validD<=0; state<=RUN.
  - stall=1: pcF, pcD, validD hold. Then:
    - if state=RUN: holdInstr<=imemData, state<=HOLD;
    - in HOLD, holdInstr is unchanged.
  - normal: pcD<=pcF; pcF<=pcF+1; validD<=1; state<=RUN.
- During stall, imemAddr stays at pcF. The ROM re-reads pcF, so on release imemData is already aligned with the new pcD.
- stall with validD=0: state still moves to HOLD (harmless), and instruction stays NOP.
- Reset asserted mid-operation, including in HOLD: immediate return to reset values. No partial state survives.
- Outputs PC and validD are registered. instruction is combinational from imemData / holdInstr, so there is no extra latency.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs fetchCount (WIDTH) and stallCount (WIDTH).
  - Both reset to 0.
  - fetchCount increments on each normal-advance edge.
  - stallCount increments on each edge with stall=1 and branchTaken=0.
  - Both wrap modulo 2^WIDTH.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - NOP constant (INSTRUCTIONWIDTH'b0, opcode 0000);
  - state enum {RUN, HOLD};
  - default RESETPC.
- One natural sub-module: fetch_pc_gen, the pcF register plus next-PC priority mux (branch / hold / increment).
- The stage register, HOLD FSM and output muxing remain in fetch_stage.

Test Plan:
- Reset release, ROM mem[i]=i+1, no control:
  - cycle 1: PC=0, instruction=24'h000001, validD=1;
  - cycle 2: PC=1, instruction=24'h000002;
  - before cycle 1: NOP with validD=0.
- stall high 3 cycles while PC=2:
  - PC=2 and instruction=24'h000003 held for all 3 cycles; imemAddr=3 throughout;
  - after release: PC=3, instruction=24'h000004, with no skipped or duplicated instruction.
- branchTaken=1, branchTarget=32'h10 while PC=4:
  - next cycle validD=0, instruction=NOP;
  - following cycle PC=16, instruction=24'h000011.
- branchTaken=1 together with stall=1: the branch wins, producing the same result as the previous case; state returns to RUN.
- flush=1 one cycle at PC=5: next output is a bubble (validD=0); the cycle after shows PC=7. The instruction at address 6 is squashed by design.
- reset pulsed low mid-HOLD: outputs go to PC=0, NOP, validD=0 asynchronously. With FETCH_PERF_EN defined, fetchCount and stallCount read 0 after reset.
